pio_write_arbiter: RTL and testbench
====================================

PIO_WRITE_ARBITER -- requirements
Module: pio_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_W, default 27, PIO output-register width (1..32).
REQ-003 clk  input  1  clock; every register updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester write request, level, held until grant.
REQ-006 req_data  input  NUM_REQ*DATA_W  per-requester value; slice i is bits [i*DATA_W +: DATA_W].
REQ-007 grant  output  NUM_REQ  one-hot, one-cycle pulse marking the accepted requester.
REQ-008 done  output  1  one-cycle pulse at transaction completion.
REQ-009 err  output  1  one-cycle pulse coincident with done on readback mismatch (readback builds only).
REQ-010 err_count  output  8  saturating readback-mismatch counter.
REQ-011 avm_address  output  2  Avalon-MM address to the PIO slave; always 0.
REQ-012 avm_chipselect  output  1  Avalon-MM chipselect.
REQ-013 avm_write_n  output  1  Avalon-MM write strobe, active-low.
REQ-014 avm_writedata  output  32  zero-extended DATA_W value.
REQ-015 avm_readdata  input  32  PIO readdata; zero-wait-state, valid in the same cycle as chipselect.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ, DONE, and only these.
REQ-017 IDLE: when any req bit is set, the block SHALL select a winner round-robin, starting at (last_winner+1) mod NUM_REQ, latch its req_data, and enter WRITE on the next edge.
REQ-018 IDLE with req==0 SHALL remain in IDLE with all strobes inactive.
REQ-019 WRITE (exactly one cycle): avm_chipselect=1, avm_write_n=0, avm_writedata={zeros, latched data}, grant=onehot(winner), last_winner<=winner.
REQ-020 WRITE SHALL go to READ when readback is compiled in, otherwise to DONE.
REQ-021 READ (exactly one cycle): avm_chipselect=1, avm_write_n=1; compare avm_readdata[DATA_W-1:0] with latched data; register mismatch; go to DONE.
REQ-022 DONE (exactly one cycle): done=1, err=registered mismatch, err_count increments on mismatch, saturates at 255; go to IDLE.
REQ-023 Latency: req sampled in IDLE at cycle N -> grant and write at N+1 -> done at N+2 (N+3 with readback); one transaction per 3 (4) cycles.
REQ-024 A req deasserted before its grant SHALL be dropped without side effects; req bits changing outside IDLE SHALL be ignored.
REQ-025 Round-robin wrap: after winner NUM_REQ-1, requester 0 SHALL have highest priority.
REQ-026 Outside WRITE/READ, avm_chipselect=0 and avm_write_n=1; avm_address SHALL be constant 0.

Reset
REQ-027 Asserting reset_n low SHALL immediately force state=IDLE, last_winner=NUM_REQ-1 (requester 0 first), grant=0, done=0, err=0, err_count=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0.
REQ-028 Reset mid-transaction SHALL abort it with no done pulse; the interrupted write is not retried.

Configuration
REQ-029 Macro PIO_WRITE_ARBITER_READBACK_EN defined: READ state, err and err_count active as above.
REQ-030 Macro undefined: READ state absent, err tied 0, err_count tied 0, WRITE proceeds directly to DONE.

Structure
REQ-031 Shared package pio_arb_pkg SHALL hold the FSM state enum, the PIO register address constant (0), and the Avalon data width constant (32).
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last_winner, outputs one-hot winner and its index); everything else stays in pio_write_arbiter.

Verification
REQ-033 Single request: req=4'b0010, data1=27'h5A5A5A1 -> grant=0010 and write of 32'h05A5A5A1 at N+1, done at N+2 (N+3 with readback).
REQ-034 Contention: req=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, one per transaction.
REQ-035 Wrap: last winner 3, req=4'b1001 -> grant 0001; next transaction grant 1000.
REQ-036 Readback mismatch (READBACK_EN): slave returns data XOR 1 -> err=1 with done, err_count 0->1; 300 mismatches -> err_count=255.
REQ-037 Reset in WRITE: reset_n low for 1 cycle -> chipselect=0, no done, state IDLE; req=4'b0001 afterwards -> grant 0001.
REQ-038 Early drop: req=4'b0100 deasserted in the cycle after the IDLE sample -> transaction still completes with the latched data; a req raised and dropped during WRITE -> no grant.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// pio_arb_pkg: shared FSM state encoding and Avalon-MM constants for the PIO write arbiter.
// Revision: 1.0
`default_nettype none

package pio_arb_pkg;

    typedef logic [1:0] pio_state_t;

    localparam pio_state_t ST_IDLE  = 2'd0;
    localparam pio_state_t ST_WRITE = 2'd1;
    localparam pio_state_t ST_READ  = 2'd2;
    localparam pio_state_t ST_DONE  = 2'd3;

    localparam logic [1:0] PIO_REG_ADDR = 2'd0;
    localparam int         AVM_DATA_W   = 32;
    localparam int         ERR_COUNT_W  = 8;

endpackage

`default_nettype wire

// File: rtl/pio_write_arbiter_if.sv
// pio_write_arbiter_if: requester handshake plus Avalon-MM master bus toward the PIO slave.
// Revision: 1.0
`default_nettype none

interface pio_write_arbiter_if
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 27
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      done;
    logic                      err;
    logic [ERR_COUNT_W-1:0]    err_count;
    logic [1:0]                avm_address;
    logic                      avm_chipselect;
    logic                      avm_write_n;
    logic [AVM_DATA_W-1:0]     avm_writedata;
    logic [AVM_DATA_W-1:0]     avm_readdata;

    // Arbiter side: owns the Avalon master signals and the grant/done returns.
    modport master (
        input  req, req_data, avm_readdata,
        output grant, done, err, err_count,
               avm_address, avm_chipselect, avm_write_n, avm_writedata
    );

    // Environment side: requesters and the PIO slave.
    modport slave (
        output req, req_data, avm_readdata,
        input  grant, done, err, err_count,
               avm_address, avm_chipselect, avm_write_n, avm_writedata
    );
endinterface

`default_nettype wire

// File: rtl/pio_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts just after the last winner.
// Revision: 1.0
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_winner_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand_idx;

    // Scan from lowest to highest priority so the nearest requester overwrites the rest.
    always_comb begin
        cand_idx     = '0;
        winner_idx_o = '0;
        valid_o      = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_idx = IDX_W'((int'(last_winner_i) + k) % NUM_REQ);
            if (req_i[cand_idx]) begin
                winner_idx_o = cand_idx;
                valid_o      = 1'b1;
            end
        end
    end

    always_comb begin
        winner_o = '0;
        if (valid_o) begin
            winner_o[winner_idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pio_write_arbiter.sv
// pio_write_arbiter: round-robin arbitration of PIO register writes onto an Avalon-MM master.
// Optional readback compare enabled by PIO_WRITE_ARBITER_READBACK_EN. Revision: 1.0
`default_nettype none

module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 27
) (
    input logic                 clk,
    input logic                 reset_n,
    pio_write_arbiter_if.master bus
);

    localparam int               IDX_W      = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

    pio_state_t         state_q;
    pio_state_t         state_d;
    logic [IDX_W-1:0]   last_winner_q;
    logic [IDX_W-1:0]   winner_idx_q;
    logic [DATA_W-1:0]  data_q;

    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i         (bus.req),
        .last_winner_i (last_winner_q),
        .winner_o      (arb_winner),
        .winner_idx_o  (arb_idx),
        .valid_o       (arb_valid)
    );

    assign sel_data = bus.req_data[arb_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_valid) state_d = ST_WRITE;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
            ST_WRITE: state_d = ST_READ;
            ST_READ:  state_d = ST_DONE;
`else
            ST_WRITE: state_d = ST_DONE;
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Winner and its data are captured at the IDLE sample; later req changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_winner_q <= LAST_RESET;
            winner_idx_q  <= '0;
            data_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && arb_valid) begin
                winner_idx_q <= arb_idx;
                data_q       <= sel_data;
            end
            if (state_q == ST_WRITE) begin
                last_winner_q <= winner_idx_q;
            end
        end
    end

`ifdef PIO_WRITE_ARBITER_READBACK_EN
    logic                   mismatch_q;
    logic [ERR_COUNT_W-1:0] err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (state_q == ST_READ) begin
                mismatch_q <= (bus.avm_readdata[DATA_W-1:0] != data_q);
            end
            if (state_q == ST_DONE && mismatch_q && err_count_q != '1) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign bus.err       = (state_q == ST_DONE) && mismatch_q;
    assign bus.err_count = err_count_q;
`else
    assign bus.err       = 1'b0;
    assign bus.err_count = '0;
`endif

    // Readdata bits above DATA_W (and all of it without readback) are intentionally ignored.
    logic unused_readdata;
    assign unused_readdata = ^bus.avm_readdata;

    always_comb begin
        bus.grant = '0;
        if (state_q == ST_WRITE) begin
            bus.grant[winner_idx_q] = 1'b1;
        end
    end

    always_comb begin
        bus.avm_writedata             = '0;
        bus.avm_writedata[DATA_W-1:0] = data_q;
    end

    assign bus.done           = (state_q == ST_DONE);
    assign bus.avm_address    = PIO_REG_ADDR;
    assign bus.avm_chipselect = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign bus.avm_write_n    = (state_q != ST_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_pio_write_arbiter.sv
// tb_pio_write_arbiter: randomized scoreboard bench with a transaction-level reference model.
// Revision: 1.0
`default_nettype none

module tb_pio_write_arbiter;
    import pio_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 27;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
    localparam int TXN_LEN = 4;
    localparam bit RB      = 1'b1;
`else
    localparam int TXN_LEN = 3;
    localparam bit RB      = 1'b0;
`endif

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] grant;
        logic [31:0]        wdata;
    } gexp_t;

    typedef struct {
        int   cyc;
        logic err;
    } dexp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pio_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    pio_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    gexp_t       gq[$];
    dexp_t       dq[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    int          free_edge = 0;
    int          model_last = NUM_REQ - 1;
    int          model_errcnt = 0;
    logic        corrupt = 1'b0;
    logic [31:0] pio_reg = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PIO slave: holds the last written value, optionally returns it with bit 0 flipped.
    always @(negedge clk) begin
        if (bus.avm_chipselect && !bus.avm_write_n) pio_reg <= bus.avm_writedata;
    end
    assign bus.avm_readdata = pio_reg ^ {31'b0, corrupt};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: a free arbiter accepts any nonzero req at an edge and is busy TXN_LEN edges.
    task automatic model_sample(input int e, input logic [NUM_REQ-1:0] r,
                                input logic [NUM_REQ*DATA_W-1:0] d);
        int    w;
        gexp_t g;
        dexp_t x;
        if (e < free_edge || r == '0) return;
        w = -1;
        for (int k = 1; k <= NUM_REQ && w < 0; k++) begin
            if (r[(model_last + k) % NUM_REQ]) w = (model_last + k) % NUM_REQ;
        end
        g.cyc   = e;
        g.grant = NUM_REQ'(1 << w);
        g.wdata = 32'(d[w*DATA_W +: DATA_W]);
        x.cyc   = e + TXN_LEN - 2;
        x.err   = RB ? corrupt : 1'b0;
        gq.push_back(g);
        dq.push_back(x);
        model_last = w;
        free_edge  = e + TXN_LEN;
    endtask

    function automatic logic [NUM_REQ*DATA_W-1:0] rand_data();
        logic [NUM_REQ*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    task automatic drive(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*DATA_W-1:0] d);
        @(posedge clk);
        #1;
        bus.req      = r;
        bus.req_data = d;
        model_sample(edge_cnt + 1, r, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, rand_data());
    endtask

    // Monitor: pops expectations when their cycle arrives, otherwise requires quiet outputs.
    always @(negedge clk) begin
        gexp_t g;
        dexp_t x;
        if (!reset_n) begin
            gq.delete();
            dq.delete();
            model_errcnt = 0;
        end else begin
            check("err_count", 32'(bus.err_count), 32'(model_errcnt));
            check("avm_address", 32'(bus.avm_address), 32'd0);
            if (gq.size() > 0 && gq[0].cyc <= edge_cnt) begin
                g = gq.pop_front();
                check("grant_cycle", 32'(edge_cnt), 32'(g.cyc));
                check("grant", 32'(bus.grant), 32'(g.grant));
                check("writedata", bus.avm_writedata, g.wdata);
                check("write_strobes", {30'b0, bus.avm_chipselect, bus.avm_write_n}, 32'b10);
            end else begin
                check("grant_quiet", 32'(bus.grant), 32'd0);
                check("write_n_quiet", 32'(bus.avm_write_n), 32'd1);
            end
            if (dq.size() > 0 && dq[0].cyc <= edge_cnt) begin
                x = dq.pop_front();
                check("done_cycle", 32'(edge_cnt), 32'(x.cyc));
                check("done", 32'(bus.done), 32'd1);
                check("err", 32'(bus.err), 32'(x.err));
                check("cs_in_done", 32'(bus.avm_chipselect), 32'd0);
                if (x.err && model_errcnt < 255) model_errcnt = model_errcnt + 1;
            end else begin
                check("done_quiet", {30'b0, bus.done, bus.err}, 32'd0);
            end
        end
    end

    initial begin
        logic [NUM_REQ*DATA_W-1:0] d;
        int                        waited;
        bus.req      = '0;
        bus.req_data = '0;
        #1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_cs", 32'(bus.avm_chipselect), 32'd0);
        check("rst_write_n", 32'(bus.avm_write_n), 32'd1);
        check("rst_writedata", bus.avm_writedata, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Single request from requester 1.
        d = rand_data();
        d[1*DATA_W +: DATA_W] = 27'h5A5A5A1;
        drive(4'b0010, d);
        idle(TXN_LEN + 2);

        // Full contention: rotation 0,1,2,3,0.
        for (int i = 0; i < 5 * TXN_LEN; i++) drive(4'b1111, rand_data());
        idle(TXN_LEN + 2);

        // Wrap: after winner 3, requester 0 goes first, then 3.
        drive(4'b1000, rand_data());
        idle(TXN_LEN + 2);
        for (int i = 0; i < 2 * TXN_LEN; i++) drive(4'b1001, rand_data());
        idle(TXN_LEN + 2);

        // Reset landing in the WRITE cycle aborts the transaction.
        drive(4'b0001, rand_data());
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_n  = 1'b0;
        bus.req  = '0;
        #1;
        check("midrst_cs", 32'(bus.avm_chipselect), 32'd0);
        check("midrst_grant", 32'(bus.grant), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        #1;
        reset_n    = 1'b1;
        model_last = NUM_REQ - 1;
        free_edge  = 0;
        idle(2);
        drive(4'b0001, rand_data());
        idle(TXN_LEN + 2);

        // Random traffic: req may drop early or toggle mid-transaction.
        for (int i = 0; i < 600; i++) drive(NUM_REQ'($urandom), rand_data());
        idle(TXN_LEN + 2);

        // Readback corruption long enough to saturate the counter.
        corrupt = 1'b1;
        for (int i = 0; i < 310 * TXN_LEN; i++) begin
            drive(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), rand_data());
        end
        idle(TXN_LEN + 2);
        corrupt = 1'b0;
        check("err_count_final", 32'(bus.err_count), RB ? 32'd255 : 32'd0);

        waited = 0;
        while ((gq.size() > 0 || dq.size() > 0) && waited < 20) begin
            idle(1);
            waited++;
        end
        check("queues_drained", 32'(gq.size() + dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
